// File: rtl/signed_addsub_pipe.sv
// Pipelined signed add/subtract with valid/ready flow control, optional saturation
// and a sticky overflow flag. The operation is computed in stage 0; the result is resolved in the last stage.
module signed_addsub_pipe #(
    parameter int SIZE     = 8,
    parameter int STAGES   = 2,
    parameter int SATURATE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_a,
    input  logic [SIZE-1:0] in_b,
    input  logic            in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_result,
    output logic [SIZE:0]   out_wide,
    output logic            out_overflow,
    output logic            ovf_sticky,
    input  logic            clr_sticky
);

    localparam int W = SIZE + 1;

    function automatic logic [W-1:0] addsub(input logic [SIZE-1:0] a,
                                            input logic [SIZE-1:0] b,
                                            input logic            op);
        logic [W-1:0] ax;
        logic [W-1:0] bx;
        logic [W-1:0] r;
        ax = {a[SIZE-1], a};
        bx = {b[SIZE-1], b};
        if (op) begin
            r = ax - bx;
        end else begin
            r = ax + bx;
        end
        return r;
    endfunction

    function automatic logic is_ovf(input logic [W-1:0] e);
        return e[SIZE] ^ e[SIZE-1];
    endfunction

    // Clamp toward the sign of the exact result, or wrap to the low bits.
    function automatic logic [SIZE-1:0] select_result(input logic [W-1:0] e);
        logic [SIZE-1:0] r;
        if ((SATURATE != 0) && is_ovf(e)) begin
            if (e[SIZE]) begin
                r = {1'b1, {(SIZE-1){1'b0}}};
            end else begin
                r = {1'b0, {(SIZE-1){1'b1}}};
            end
        end else begin
            r = e[SIZE-1:0];
        end
        return r;
    endfunction

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [W-1:0]      wide_q [STAGES];
    logic [W-1:0]      wide_d [STAGES];
    logic [SIZE-1:0]   result_q;
    logic [SIZE-1:0]   result_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              sticky_q;
    logic              sticky_d;
    logic              advance_s;
    logic              take_s;
    logic              xfer_s;

    // Global advance and stage shifting; payloads only load under a valid bit.
    always_comb begin
        advance_s = !vld_q[STAGES-1] || out_ready;
        take_s    = in_valid && advance_s;
        xfer_s    = vld_q[STAGES-1] && out_ready;
        vld_d     = vld_q;
        wide_d    = wide_q;
        if (advance_s) begin
            vld_d[0] = take_s;
            if (take_s) begin
                wide_d[0] = addsub(in_a, in_b, in_op);
            end else begin
                wide_d[0] = wide_q[0];
            end
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    wide_d[i] = wide_q[i-1];
                end else begin
                    wide_d[i] = wide_q[i];
                end
            end
        end else begin
            vld_d  = vld_q;
            wide_d = wide_q;
        end
    end

    // Final-stage result selection follows whatever the last wide register will hold.
    always_comb begin
        result_d = select_result(wide_d[STAGES-1]);
        ovf_d    = is_ovf(wide_d[STAGES-1]);
    end

    // Sticky overflow: a delivered overflow beats a simultaneous clear.
    always_comb begin
        if (xfer_s && ovf_q) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // State registers with synchronous reset; reset discards all in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= {STAGES{1'b0}};
            for (int i = 0; i < STAGES; i++) begin
                wide_q[i] <= {W{1'b0}};
            end
            result_q <= {SIZE{1'b0}};
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            wide_q   <= wide_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

    assign in_ready     = advance_s;
    assign out_valid    = vld_q[STAGES-1];
    assign out_result   = result_q;
    assign out_wide     = wide_q[STAGES-1];
    assign out_overflow = ovf_q;
    assign ovf_sticky   = sticky_q;

endmodule
